// File: rtl/counter_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_bcd_pkg
// Description : Shared types and constants for the binary-to-BCD converter:
//               converter state encoding, 7-segment code table (gfedcba,
//               active-high) and a helper that computes the minimum BCD
//               digit count able to hold a binary value of a given width.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_e;

    // Segment codes ordered gfedcba; index is the BCD digit value.
    // Codes 10-15 cannot occur in valid BCD and decode to all-off.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0000000,  // 15
        7'b0000000,  // 14
        7'b0000000,  // 13
        7'b0000000,  // 12
        7'b0000000,  // 11
        7'b0000000,  // 10
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    // Smallest number of decimal digits that can represent 2^width - 1.
    function automatic int min_bcd_digits(input int width);
        logic [63:0] max_val;
        logic [63:0] pow;
        int          digits;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        pow     = 64'd10;
        digits  = 1;
        // 10^19 is the largest power of ten below 2^64.
        for (int i = 0; i < 19; i++) begin
            if (pow <= max_val) begin
                digits = digits + 1;
                pow    = pow * 64'd10;
            end
        end
        return digits;
    endfunction

endpackage : counter_bcd_pkg
`default_nettype wire

// File: rtl/bcd_to_seven_seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seven_seg
// Description : Combinational single-digit BCD to 7-segment decoder.
//               Only built when COUNTER_BCD_SEVEN_SEG_EN is defined.
// Ports       : digit_i [3:0]  BCD digit
//               seg_o   [6:0]  segments gfedcba, active-high
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef COUNTER_BCD_SEVEN_SEG_EN
module bcd_to_seven_seg
    import counter_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[digit_i];

endmodule : bcd_to_seven_seg
`endif
`default_nettype wire

// File: rtl/counter_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : counter_bcd_converter
// Description : Captures a binary value on start_i and converts it to packed
//               BCD with a sequential shift-add-3 (double dabble) engine, one
//               bit per clock. Result is presented on bcd_o with a one-cycle
//               valid_o pulse; bcd_o holds until the next completion.
// Ports       : clock_i   system clock (rising edge)
//               reset_i   asynchronous active-low reset
//               start_i   conversion request, sampled only when idle
//               value_i   binary value, sampled with an accepted start_i
//               busy_o    conversion in progress
//               valid_o   one-cycle pulse, bcd_o just updated
//               bcd_o     packed BCD result, digit 0 in [3:0]
//               seg_o     (COUNTER_BCD_SEVEN_SEG_EN only) 7-segment codes,
//                         gfedcba per digit, leading zeros blanked
// Options     : COUNTER_BCD_SEVEN_SEG_EN adds seg_o and its decoders.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_bcd_converter
    import counter_bcd_pkg::*;
#(
    parameter int VALUE_WIDTH = 6,
    parameter int DIGITS      = 2
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [VALUE_WIDTH-1:0] value_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [4*DIGITS-1:0]    bcd_o
`ifdef COUNTER_BCD_SEVEN_SEG_EN
    ,
    output logic [7*DIGITS-1:0]    seg_o
`endif
);

    localparam int                CNT_W    = $clog2(VALUE_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(VALUE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject configurations whose digit count cannot hold the largest input.
    if (DIGITS < min_bcd_digits(VALUE_WIDTH)) begin : g_digits_check
        $fatal(1, "counter_bcd_converter: DIGITS too small for VALUE_WIDTH");
    end

    conv_state_e               state_q;
    logic [VALUE_WIDTH-1:0]    bin_q;
    logic [VALUE_WIDTH-1:0]    bin_d;
    logic [4*DIGITS-1:0]       scratch_q;
    logic [4*DIGITS-1:0]       scratch_adj;
    logic [4*DIGITS-1:0]       scratch_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      busy_q;
    logic                      valid_q;
    logic [4*DIGITS-1:0]       bcd_q;

    // One double-dabble iteration: correct each digit, then shift the
    // binary MSB into the scratch LSB.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {scratch_d, bin_d} = {scratch_adj, bin_q} << 1;
    end

`ifdef COUNTER_BCD_SEVEN_SEG_EN
    logic [7*DIGITS-1:0] seg_raw;
    logic [7*DIGITS-1:0] seg_d;
    logic [7*DIGITS-1:0] seg_q;
    logic                upper_zero;

    // Decode the final scratch value so seg_q loads on the same edge as bcd_q.
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg_dec
        bcd_to_seven_seg u_dec (
            .digit_i (scratch_d[4*g +: 4]),
            .seg_o   (seg_raw[7*g +: 7])
        );
    end

    // Blank a digit when it and every digit above it are zero; digit 0
    // always shows so a zero result displays as "0".
    always_comb begin
        seg_d      = seg_raw;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (scratch_d[4*i +: 4] == 4'd0);
            if (upper_zero) begin
                seg_d[7*i +: 7] = 7'd0;
            end
        end
    end

    assign seg_o = seg_q;
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            bcd_q     <= '0;
`ifdef COUNTER_BCD_SEVEN_SEG_EN
            seg_q     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q     <= value_i;
                        scratch_q <= '0;
                        cnt_q     <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q     <= bin_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q - CNT_ONE;
                    // Last iteration: publish the result directly from the
                    // next-state scratch so no intermediate value is exposed.
                    if (cnt_q == CNT_ONE) begin
                        bcd_q   <= scratch_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef COUNTER_BCD_SEVEN_SEG_EN
                        seg_q   <= seg_d;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign bcd_o   = bcd_q;

endmodule : counter_bcd_converter
`default_nettype wire

// File: doc/counter_bcd_converter.md
Name: counter_bcd_converter

Overview:
- Downstream consumer of the counter stage: captures the binary counter value on a start strobe, typically the counter's finished pulse.
- Converts the value to packed BCD with a sequential shift-add-3 (double dabble) engine, one bit per clock.
- Presents the digits, with a one-cycle valid pulse, to the display/output logic of the tile.

Parameters:
- VALUE_WIDTH, 6, width of the binary input; matches the counter value width for a maximum count of 33.
- DIGITS, 2, number of BCD digits produced; must satisfy 10^DIGITS > 2^VALUE_WIDTH - 1 (elaboration-time check, fatal on violation).

Ports:
- clock_i  input  1  system clock; all state changes on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- start_i  input  1  conversion request; sampled only in IDLE.
- value_i  input  VALUE_WIDTH  binary value; sampled on the same edge as an accepted start_i.
- busy_o  output  1  high while a conversion is in progress.
- valid_o  output  1  one-cycle pulse; bcd_o has just been updated.
- bcd_o  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].

Behaviour:
- Reset (reset_i low, asynchronous): state IDLE; busy_o=0, valid_o=0, bcd_o=0; shift register and bit counter cleared. Release is sampled synchronously.
- States: IDLE, SHIFT.
- IDLE: on an edge with start_i=1:
  - load value_i into the binary shift register;
  - clear the BCD scratch register;
  - load bit counter = VALUE_WIDTH;
  - go to SHIFT; busy_o=1 from that edge.
- SHIFT: each edge performs one iteration:
  - every scratch digit >= 5 gets +3;
  - then {scratch, binary} shifts left by one (binary MSB enters scratch LSB);
  - counter decrements.
- The edge that performs iteration VALUE_WIDTH (counter reaching 0):
  - bcd_o <= final scratch;
  - valid_o=1 for exactly one cycle;
  - busy_o=0;
  - return to IDLE.
- Latency: start sampled at edge k gives valid_o high after edge k+VALUE_WIDTH (k+6 by default).
- Throughput: start held high gives one conversion per VALUE_WIDTH+1 cycles. A start in the cycle valid_o is high is accepted.
- start_i while busy_o=1 is ignored. No queueing; value_i changes during SHIFT have no effect.
- bcd_o holds the last result until the next completion; it never shows intermediate scratch values.
- Arithmetic: add-3 is applied per 4-bit digit before the shift; the scratch register is exactly 4*DIGITS bits; no overflow is possible given the parameter check.
- Reset asserted mid-conversion: immediate return to reset state; no valid_o pulse; the partial result is discarded.
- value_i=0 still takes the full VALUE_WIDTH iterations (no early exit).

Optional Feature:
- Macro COUNTER_BCD_SEVEN_SEG_EN.
- Defined:
  - adds output seg_o, width 7*DIGITS, active-high segments ordered gfedcba per digit, digit 0 in bits [6:0];
  - seg_o is registered on the same edge as bcd_o;
  - leading-zero blanking: any digit above digit 0 that is zero and has only zero digits above it drives 0000000;
  - seg_o resets to 0.
- Undefined: seg_o port and decode logic absent; all other behaviour identical.

Decomposition:
- Shared package counter_bcd_pkg:
  - state enum (IDLE, SHIFT);
  - 16-entry 7-segment constant table (codes 10-15 map to 0000000);
  - helper function computing minimum DIGITS for a given VALUE_WIDTH, used by the elaboration check.
- One natural sub-module: bcd_to_seven_seg, a per-digit combinational decoder. It is instantiated DIGITS times, only under COUNTER_BCD_SEVEN_SEG_EN.

Test Plan:
- value_i=33, start_i pulse → busy_o high 6 cycles; valid_o pulses after edge k+6; bcd_o=0x33.
- value_i=0, then value_i=63 back-to-back with start_i held high → bcd_o=0x00 then 0x63; valid_o pulses 7 cycles apart.
- start_i pulsed with value_i=9, then start_i pulsed with value_i=50 two cycles later (mid-conversion) → second start ignored; bcd_o=0x09; only one valid_o pulse.
- reset_i driven low at iteration 3 of a 33 conversion → busy_o=0, valid_o=0, bcd_o=0 immediately (asynchronous); no valid_o after release.
- value_i changed to 12 during SHIFT after starting with 27 → result bcd_o=0x27.
- COUNTER_BCD_SEVEN_SEG_EN defined:
  - value_i=33 → seg_o = {1001111, 1001111};
  - value_i=7 → seg_o = {0000000 (blanked), 0000111}.
